// File: rtl/led_event_pkg.sv
// Shared definitions for the LED event arbiter: FSM encoding, clog2, leds layout.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package led_event_pkg;

   // Display FSM: waiting for a request, or holding an event on the LEDs.
   typedef enum logic {
      IDLE = 1'b0,
      SHOW = 1'b1
   } state_e;

   // leds = {one-hot source channel, payload}; payload sits at the bottom.
   localparam int LEDS_DATA_LSB = 0;

   // The channel one-hot field starts right above the payload.
   function automatic int leds_chan_lsb(input int data_w);
      return data_w;
   endfunction

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/led_event_arbiter_if.sv
// Event-source / LED-side bundle of the LED event arbiter.
// Latency: n/a (wiring only).
// Backpressure: none; events are strobes and drops are reported via overflow.
interface led_event_arbiter_if #(
   parameter int CHANNELS = 4,
   parameter int DATA_W   = 8
);
   logic [CHANNELS-1:0]        in_valid;
   logic [CHANNELS*DATA_W-1:0] in_data;
   logic                       mode_rr;
   logic [CHANNELS-1:0]        chan_mask;
   logic                       clear_ovf;
   logic [DATA_W+CHANNELS-1:0] leds;
   logic                       led_active;
   logic [CHANNELS-1:0]        overflow;

   // Producer / control side.
   modport master (
      output in_valid, in_data, mode_rr, chan_mask, clear_ovf,
      input  leds, led_active, overflow
   );

   // Arbiter side.
   modport slave (
      input  in_valid, in_data, mode_rr, chan_mask, clear_ovf,
      output leds, led_active, overflow
   );
endinterface

// File: rtl/event_fifo.sv
// Single-clock FIFO with extra-wrap-bit pointers; full/empty from pointer compare.
// Latency: written entry visible on rd_data the cycle after the push edge.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module event_fifo
   import led_event_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty
);
   localparam int AW = clog2(DEPTH);

   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              push_ok;
   logic              pop_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // A pop frees the head slot on the same edge, so a push on full is safe then.
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // Pointer update; pointers wrap naturally through the extra bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
   end
endmodule

// File: rtl/led_event_arbiter.sv
// Buffers per-channel LED events, arbitrates (fixed/round-robin), holds each on the LEDs.
// Latency: event pushed at edge k reaches leds at edge k+1 when idle; held HOLD_CYCLES cycles.
// Backpressure: none upstream; per-channel FIFO drops on full and sets sticky overflow.
module led_event_arbiter
   import led_event_pkg::*;
#(
   parameter int CHANNELS    = 4,
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 4,
   parameter int HOLD_CYCLES = 50_000_000
) (
   input logic               clk,
   input logic               rst,
   led_event_arbiter_if.slave bus
);
   localparam int CNT_W = (clog2(HOLD_CYCLES) < 1) ? 1 : clog2(HOLD_CYCLES);
   localparam int LG_W  = clog2(CHANNELS);
   localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [LG_W-1:0]  LAST_RESET  = LG_W'(CHANNELS - 1);

   logic [CHANNELS-1:0]        full;
   logic [CHANNELS-1:0]        empty;
   logic [CHANNELS-1:0]        pop_vec;
   logic [CHANNELS-1:0]        req;
   logic [CHANNELS-1:0]        drop;
   logic [DATA_W-1:0]          fifo_dat [CHANNELS];

   logic                       gnt_vld;
   logic [LG_W-1:0]            gnt_idx;
   logic [CHANNELS-1:0]        gnt_oh;

   state_e                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [DATA_W+CHANNELS-1:0] leds_q, leds_d;
   logic [LG_W-1:0]            last_q, last_d;
   logic [CHANNELS-1:0]        ovf_q, ovf_d;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_fifo
      event_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .push    (bus.in_valid[g]),
         .pop     (pop_vec[g]),
         .wr_data (bus.in_data[g*DATA_W +: DATA_W]),
         .rd_data (fifo_dat[g]),
         .full    (full[g]),
         .empty   (empty[g])
      );
   end

   // Masked channels keep buffering but never request.
   assign req  = ~empty & ~bus.chan_mask;
   assign drop = bus.in_valid & full & ~pop_vec;

   // Grant selection: lowest index, or first requester after last_grant with wrap.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      gnt_oh  = '0;
      if (!bus.mode_rr) begin
         // Scan downwards so the lowest requesting index is the final assignment.
         for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (req[LG_W'(i)]) begin
               gnt_vld = 1'b1;
               gnt_idx = LG_W'(i);
            end
         end
      end else begin
         // Scan offsets downwards so the nearest channel after last_grant wins.
         for (int off = CHANNELS; off >= 1; off--) begin
            if (req[LG_W'((int'(last_q) + off) % CHANNELS)]) begin
               gnt_vld = 1'b1;
               gnt_idx = LG_W'((int'(last_q) + off) % CHANNELS);
            end
         end
      end
      gnt_oh[gnt_idx] = gnt_vld;
   end

   // Next-state, hold counter, LED load and FIFO pop for the display FSM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      leds_d  = leds_q;
      last_d  = last_q;
      pop_vec = '0;
      case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               state_d                                  = SHOW;
               pop_vec[gnt_idx]                         = 1'b1;
               leds_d[leds_chan_lsb(DATA_W) +: CHANNELS] = gnt_oh;
               leds_d[LEDS_DATA_LSB +: DATA_W]          = fifo_dat[gnt_idx];
               cnt_d                                    = HOLD_RELOAD;
               last_d                                   = gnt_idx;
            end
         end
         SHOW: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (gnt_vld) begin
               // Back-to-back: reload straight away, no idle gap.
               pop_vec[gnt_idx]                         = 1'b1;
               leds_d[leds_chan_lsb(DATA_W) +: CHANNELS] = gnt_oh;
               leds_d[LEDS_DATA_LSB +: DATA_W]          = fifo_dat[gnt_idx];
               cnt_d                                    = HOLD_RELOAD;
               last_d                                   = gnt_idx;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   // Sticky drop flags; a drop in the clearing cycle wins over the clear.
   always_comb begin
      ovf_d = bus.clear_ovf ? '0 : ovf_q;
      ovf_d = ovf_d | drop;
   end

   // Registered FSM state, display and arbitration history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         leds_q  <= '0;
         last_q  <= LAST_RESET;
         ovf_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         leds_q  <= leds_d;
         last_q  <= last_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.leds       = leds_q;
   assign bus.led_active = (state_q == SHOW);
   assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_led_event_arbiter.sv
// Directed bench for led_event_arbiter: 4 channels, 8-bit payload, depth 4, hold 4.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_led_event_arbiter;
   localparam int CH    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int HOLD  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   led_event_arbiter_if #(.CHANNELS(CH), .DATA_W(DW)) bus ();

   led_event_arbiter #(
      .CHANNELS    (CH),
      .DATA_W      (DW),
      .DEPTH       (DEPTH),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [11:0] fp_exp [3] = '{12'h100, 12'h211, 12'h833};
   logic [11:0] rr_exp [8] = '{12'h110, 12'h211, 12'h412, 12'h813,
                               12'h120, 12'h221, 12'h422, 12'h823};
   logic [11:0] rm_exp [6] = '{12'h130, 12'h432, 12'h833, 12'h140, 12'h442, 12'h843};
   logic [11:0] ov_exp [4] = '{12'h150, 12'h151, 12'h152, 12'h153};
   logic [11:0] pf_exp [5] = '{12'h160, 12'h161, 12'h162, 12'h163, 12'h164};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tickn(input int n);
      repeat (n) tick();
   endtask

   task automatic push(input logic [CH-1:0] v, input logic [CH*DW-1:0] d);
      bus.in_valid = v;
      bus.in_data  = d;
      tick();
      bus.in_valid = '0;
   endtask

   task automatic expect_show(input string tag, input logic [11:0] exp_leds);
      check(tag, 64'(bus.leds), 64'(exp_leds));
      check({tag, "_active"}, 64'(bus.led_active), 64'd1);
   endtask

   initial begin
      bus.in_valid  = '0;
      bus.in_data   = '0;
      bus.mode_rr   = 1'b0;
      bus.chan_mask = '0;
      bus.clear_ovf = 1'b0;
      tickn(2);
      check("rst_leds", 64'(bus.leds), 64'd0);
      check("rst_active", 64'(bus.led_active), 64'd0);
      check("rst_ovf", 64'(bus.overflow), 64'd0);
      rst = 1'b0;
      tick();

      // Single event on ch2: one-edge latency, four cycles of display.
      push(4'b0100, 32'h00A5_0000);
      check("single_lat_idle", 64'(bus.led_active), 64'd0);
      tick();
      expect_show("single_show", 12'h4A5);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("single_hold", 64'(bus.led_active), 64'd1);
      end
      tick();
      check("single_end_active", 64'(bus.led_active), 64'd0);
      check("single_end_leds", 64'(bus.leds), 64'h4A5);

      // Fixed priority: ch0, ch1, ch3 back-to-back, 12 continuous active cycles.
      push(4'b1011, 32'h3300_1100);
      tick();
      for (int j = 0; j < 12; j++) begin
         expect_show("fp_order", fp_exp[j / 4]);
         tick();
      end
      check("fp_end_active", 64'(bus.led_active), 64'd0);

      // Round-robin with two events per channel.
      bus.mode_rr = 1'b1;
      push(4'hF, 32'h1312_1110);
      push(4'hF, 32'h2322_2120);
      for (int k = 0; k < 8; k++) begin
         expect_show("rr_order", rr_exp[k]);
         tickn(4);
      end
      check("rr_end_active", 64'(bus.led_active), 64'd0);

      // Round-robin with ch1 masked, then drained after unmask.
      bus.chan_mask = 4'b0010;
      push(4'hF, 32'h3332_3130);
      push(4'hF, 32'h4342_4140);
      for (int k = 0; k < 6; k++) begin
         expect_show("rr_mask_order", rm_exp[k]);
         tickn(4);
      end
      check("rr_mask_idle", 64'(bus.led_active), 64'd0);
      check("rr_mask_idle_leds", 64'(bus.leds), 64'h843);
      bus.chan_mask = 4'b0000;
      tick();
      expect_show("rr_unmask_a", 12'h231);
      tickn(4);
      expect_show("rr_unmask_b", 12'h241);
      tickn(4);
      check("rr_unmask_end", 64'(bus.led_active), 64'd0);

      // Overflow on masked ch0: fifth push drops; clear coinciding with a drop keeps the flag.
      bus.chan_mask = 4'b0001;
      push(4'b0001, 32'h50);
      push(4'b0001, 32'h51);
      push(4'b0001, 32'h52);
      push(4'b0001, 32'h53);
      check("ovf_full_no_flag", 64'(bus.overflow), 64'd0);
      push(4'b0001, 32'h54);
      check("ovf_set", 64'(bus.overflow), 64'd1);
      bus.clear_ovf = 1'b1;
      push(4'b0001, 32'h55);
      bus.clear_ovf = 1'b0;
      check("ovf_clear_vs_drop", 64'(bus.overflow), 64'd1);
      check("ovf_masked_idle", 64'(bus.led_active), 64'd0);
      bus.chan_mask = 4'b0000;
      tick();
      for (int k = 0; k < 4; k++) begin
         expect_show("ovf_drain", ov_exp[k]);
         tickn(4);
      end
      check("ovf_drain_end", 64'(bus.led_active), 64'd0);
      check("ovf_still_set", 64'(bus.overflow), 64'd1);
      bus.clear_ovf = 1'b1;
      tick();
      bus.clear_ovf = 1'b0;
      check("ovf_cleared", 64'(bus.overflow), 64'd0);

      // Push on full while the same FIFO is popped: accepted, no overflow.
      bus.chan_mask = 4'b0001;
      push(4'b0001, 32'h60);
      push(4'b0001, 32'h61);
      push(4'b0001, 32'h62);
      push(4'b0001, 32'h63);
      bus.chan_mask = 4'b0000;
      push(4'b0001, 32'h64);
      check("pof_no_ovf", 64'(bus.overflow), 64'd0);
      expect_show("pof_order", pf_exp[0]);
      for (int k = 1; k < 5; k++) begin
         tickn(4);
         expect_show("pof_order", pf_exp[k]);
      end
      tickn(4);
      check("pof_end", 64'(bus.led_active), 64'd0);

      // Reset in the middle of a display with a full, overflowed ch3.
      bus.chan_mask = 4'b1000;
      push(4'b1100, 32'h7077_0000);
      push(4'b1000, 32'h7100_0000);
      push(4'b1000, 32'h7200_0000);
      push(4'b1000, 32'h7300_0000);
      push(4'b1000, 32'h7400_0000);
      check("prerst_ovf", 64'(bus.overflow), 64'h8);
      expect_show("prerst_show", 12'h477);
      rst = 1'b1;
      #1;
      check("midrst_leds", 64'(bus.leds), 64'd0);
      check("midrst_active", 64'(bus.led_active), 64'd0);
      check("midrst_ovf", 64'(bus.overflow), 64'd0);
      tickn(2);
      rst = 1'b0;
      bus.chan_mask = 4'b0000;
      tickn(3);
      check("postrst_empty_active", 64'(bus.led_active), 64'd0);
      check("postrst_empty_leds", 64'(bus.leds), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/led_event_arbiter.md
# led_event_arbiter

Parametrised successor to the fixed three-source status path in front of the LED manager. Collects pulse-valid events from CHANNELS independent sources (UART data, UART errors, CM/VGA notifications, …), buffers each in its own small FIFO, arbitrates in fixed-priority or round-robin mode, and shows each granted event on the LED bus for a programmable hold time. It sits between the event producers and the board LEDs, in the LED clock domain. Cross-domain sources are synchronised upstream.

## Interface
Parameters:
- CHANNELS, 4, number of event sources (2..8)
- DATA_W, 8, event payload width
- DEPTH, 4, per-channel FIFO depth (power of two, ≥2)
- HOLD_CYCLES, 50_000_000, clock cycles each event stays displayed (≥1)

Ports:
- clk  in  1  LED-domain clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  CHANNELS  single-cycle event strobe per channel
- in_data  in  CHANNELS*DATA_W  payload; channel i at [i*DATA_W +: DATA_W]
- mode_rr  in  1  0 = fixed priority (channel 0 highest), 1 = round-robin
- chan_mask  in  CHANNELS  1 = channel excluded from arbitration (still buffered)
- clear_ovf  in  1  clears all overflow flags
- leds  out  DATA_W+CHANNELS  {one-hot source channel, payload}
- led_active  out  1  high while an event is being displayed
- overflow  out  CHANNELS  sticky per-channel drop flag

## Operation
- Per channel: FIFO of DEPTH entries. When in_valid[i] and FIFO not full, write. When full and no pop in the same cycle, drop the event and set overflow[i]. When full with a simultaneous pop, the write is accepted.
- overflow[i] stays set until clear_ovf. If clear_ovf and a new drop occur in the same cycle, the flag stays set.
- Request vector: FIFO non-empty & ~chan_mask.
- Fixed priority grants the lowest requesting index. Round-robin searches from last_grant+1 upward with wrap; last_grant resets to CHANNELS-1, so channel 0 is checked first after reset.
- FSM states:
  - IDLE → SHOW when any request is active: pop the granted FIFO, load leds, load hold counter with HOLD_CYCLES-1, update last_grant.
  - SHOW: counter decrements each cycle. When counter==0 and a request is active, re-arbitrate and reload directly (back-to-back events, no idle gap). When counter==0 and no request is active → IDLE.
- In IDLE, leds keeps its last value and led_active=0.
- mode_rr and chan_mask are sampled only at arbitration instants. Changes mid-SHOW affect the next grant only.
- Masking a channel whose event is currently displayed does not cut the display short.

## Timing
- Reset values: leds=0, led_active=0, overflow=0, all FIFOs empty, state IDLE, counter 0, last_grant=CHANNELS-1.
- Reset asserted mid-SHOW aborts immediately. Buffered events are lost.
- Latency: event written at edge k, idle arbiter → leds/led_active update at edge k+1.
- Each event is displayed exactly HOLD_CYCLES cycles. led_active stays high continuously across back-to-back events.
- FIFO pointers are log2(DEPTH) bits with an extra wrap bit. full/empty are derived from pointer compare. Pointers wrap silently.
- Simultaneous in_valid on all channels in one cycle: all are buffered; no drop unless the individual FIFO is full.

## Structure
- Shared package led_event_pkg: FSM state encoding (IDLE, SHOW), a clog2 function, and the leds field layout constants.
- One sub-module, event_fifo (DATA_W, DEPTH): synchronous single-clock FIFO with push, pop, full, empty. Instantiated CHANNELS times via generate.
- Arbiter and hold counter live in the top module.

## Test plan
- HOLD_CYCLES=4, single event ch2 data 0xA5 → after the next edge leds={0100,0xA5}, led_active high for exactly 4 cycles, then low with leds unchanged.
- Fixed priority: ch3=0x33, ch1=0x11, ch0=0x00 in the same cycle → display order ch0, ch1, ch3, back-to-back, 12 cycles of continuous led_active.
- Round-robin: two events queued on every channel → grant order 0,1,2,3,0,1,2,3. With ch1 masked → 0,2,3,0,2,3, and ch1 is drained after unmask.
- Overflow: DEPTH=4, HOLD large, five events on ch0 with ch0 masked → overflow[0]=1 and only the first four are later displayed. clear_ovf → overflow[0]=0.
- Push-on-full with simultaneous pop → event accepted, no overflow. Reset asserted mid-SHOW → all outputs return to reset values on the same edge, and FIFOs are empty after release.
